// File: rtl/mastermind_pkg.sv
// Shared Mastermind constants: keyboard code map, colour width and entry FSM states.
package mastermind_pkg;

    localparam int unsigned COLOR_W = 3;

    localparam logic [4:0] KB_NONE      = 5'b00000;
    localparam logic [4:0] KB_SUBMIT    = 5'b10000;
    localparam logic [1:0] KB_COLOR_PFX = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StFull,
        StSubmit
    } entry_state_e;

    function automatic logic is_color(input logic [4:0] code);
        return code[4:3] == KB_COLOR_PFX;
    endfunction

    function automatic logic is_actionable(input logic [4:0] code);
        return is_color(code) || (code == KB_SUBMIT);
    endfunction

endpackage

// File: rtl/kb_press_filter.sv
// Turns a held key code into a single press strobe once it has been stable long enough.
module kb_press_filter
    import mastermind_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] kb_code_i,
    output logic       press_o,
    output logic [4:0] code_o
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    logic [4:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fired_q, fired_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        fired_d = fired_q;
        if (kb_code_i != cand_q) begin
            cand_d  = kb_code_i;
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!fired_q && (cand_q != KB_NONE)) begin
            fired_d = 1'b1;
        end
    end

    // Strobe is combinational so the consumer acts on the same edge that sets fired.
    assign press_o = (kb_code_i == cand_q) && (cnt_q == CntMax) && !fired_q
                     && is_actionable(cand_q);
    assign code_o  = cand_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= KB_NONE;
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Collects debounced colour presses into a guess and offers it to the game FSM via valid/ready.
module guess_entry_ctrl
    import mastermind_pkg::*;
#(
    parameter int unsigned SLOTS         = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               kb_code,
    input  logic                     turn_en,
    input  logic                     guess_ready,
    output logic [SLOTS*COLOR_W-1:0] guess,
    output logic [2:0]               slot_count,
    output logic                     guess_valid,
    output logic                     reject,
    output logic                     key_pulse
);

    localparam int unsigned GuessW = SLOTS * COLOR_W;

    logic       press;
    logic [4:0] press_code;
    logic       ev_color, ev_submit;

    kb_press_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .kb_code_i(kb_code),
        .press_o  (press),
        .code_o   (press_code)
    );

    assign ev_color  = press && is_color(press_code);
    assign ev_submit = press && (press_code == KB_SUBMIT);

    entry_state_e      state_q, state_d;
    logic [GuessW-1:0] guess_q, guess_d;
    logic [2:0]        slot_cnt_q, slot_cnt_d;
    logic              reject_q, reject_d;
    logic              key_pulse_q, key_pulse_d;

    always_comb begin
        state_d     = state_q;
        guess_d     = guess_q;
        slot_cnt_d  = slot_cnt_q;
        reject_d    = 1'b0;
        key_pulse_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                guess_d    = '0;
                slot_cnt_d = '0;
                if (turn_en) state_d = StEntry;
            end
            StEntry: begin
                if (!turn_en) begin
                    guess_d    = '0;
                    slot_cnt_d = '0;
                    state_d    = StIdle;
                end else if (ev_color) begin
                    for (int unsigned i = 0; i < SLOTS; i++) begin
                        if (slot_cnt_q == 3'(i)) begin
                            guess_d[i*COLOR_W +: COLOR_W] = press_code[COLOR_W-1:0];
                        end
                    end
                    slot_cnt_d  = slot_cnt_q + 3'd1;
                    key_pulse_d = 1'b1;
                    if (slot_cnt_q == 3'(SLOTS - 1)) state_d = StFull;
                end else if (ev_submit) begin
                    reject_d = 1'b1;
                end
            end
            StFull: begin
                if (!turn_en) begin
                    guess_d    = '0;
                    slot_cnt_d = '0;
                    state_d    = StIdle;
                end else if (ev_submit) begin
                    key_pulse_d = 1'b1;
                    state_d     = StSubmit;
                end else if (ev_color) begin
                    reject_d = 1'b1;
                end
            end
            StSubmit: begin
                // Offer is held regardless of turn_en until the game FSM takes it.
                if (guess_ready) begin
                    guess_d    = '0;
                    slot_cnt_d = '0;
                    state_d    = StIdle;
                end
            end
            default: begin
                guess_d    = '0;
                slot_cnt_d = '0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            guess_q     <= '0;
            slot_cnt_q  <= '0;
            reject_q    <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            guess_q     <= guess_d;
            slot_cnt_q  <= slot_cnt_d;
            reject_q    <= reject_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign guess       = guess_q;
    assign slot_count  = slot_cnt_q;
    assign guess_valid = (state_q == StSubmit);
    assign reject      = reject_q;
    assign key_pulse   = key_pulse_q;

endmodule
